// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH clock-enable strobes from one master clock, runtime divisors, resync and stall gating.
// Latency: clk_en is combinational from phase registers; cyc_cnt/cyc_par update on the edge ending a strobe.
// No backpressure; stall masks clk_en_g only. Define CLK_EN_GEN_CYC_CNT_EN for full cycle counters.
module clk_en_gen #(
    parameter int                       NUM_CH   = 3,
    parameter int                       DIV_W    = 8,
    parameter int                       CYC_W    = 64,
    parameter logic [NUM_CH*DIV_W-1:0]  DIV_INIT = {8'd24, 8'd12, 8'd4}
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      run,
    input  logic                                      resync,
    input  logic                                      cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                          cfg_div,
    input  logic [NUM_CH-1:0]                         stall,
    output logic [NUM_CH-1:0]                         clk_en,
    output logic [NUM_CH-1:0]                         clk_en_g,
    output logic [NUM_CH*CYC_W-1:0]                   cyc_cnt,
    output logic [NUM_CH-1:0]                         cyc_par
);
    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    assign clk_en_g = clk_en & ~stall;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_cur;
        logic [DIV_W-1:0] div_nxt;
        logic [DIV_W-1:0] wrap_val;
        logic             wr_hit;

        // A programmed divisor of 0 behaves like 1: wrap point is phase 0.
        assign wrap_val  = (div_cur == '0) ? '0 : div_cur - DIV_ONE;
        assign clk_en[k] = run & (cnt == wrap_val);
        assign wr_hit    = cfg_we & (cfg_ch == CH_W'(k));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                div_cur <= DIV_INIT[k*DIV_W +: DIV_W];
                div_nxt <= DIV_INIT[k*DIV_W +: DIV_W];
            end else begin
                if (wr_hit) begin
                    div_nxt <= cfg_div;
                end
                // Divisor changes land only at a wrap or resync, so no period is truncated.
                if (resync) begin
                    cnt     <= '0;
                    div_cur <= wr_hit ? cfg_div : div_nxt;
                end else if (clk_en[k]) begin
                    cnt     <= '0;
                    div_cur <= div_nxt;
                end else if (run) begin
                    cnt     <= cnt + DIV_ONE;
                end
            end
        end

`ifdef CLK_EN_GEN_CYC_CNT_EN
        logic [CYC_W-1:0] cyc_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cyc_q <= '0;
            end else if (clk_en[k]) begin
                cyc_q <= cyc_q + {{(CYC_W-1){1'b0}}, 1'b1};
            end
        end

        assign cyc_cnt[k*CYC_W +: CYC_W] = cyc_q;
        assign cyc_par[k]                = cyc_q[0];
`else
        // Only the parity bit is kept; it toggles exactly where counter bit 0 would.
        logic par_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                par_q <= 1'b0;
            end else if (clk_en[k]) begin
                par_q <= ~par_q;
            end
        end

        assign cyc_cnt[k*CYC_W +: CYC_W] = '0;
        assign cyc_par[k]                = par_q;
`endif
    end
endmodule
